mmio_aic: RTL and testbench
===========================

# mmio_aic

Parametrised successor to the MMIO front end: decodes a relocatable Advanced Interrupt Controller Table (AICT) window out of the CPU memory stream, forwards all other accesses to SRAM unchanged, and runs an N-line interrupt controller with edge capture, per-line enable, write-1-clear pending, priority select and an in-service handshake. It sits between the core's memory port and the SRAM controller, and drives the core's interrupt-request inputs.

## Interface
Parameters:
- NIRQ, 24, number of interrupt lines (2..32); line 0 is the NMI
- BASE_RST, 32'h0000_FF00, reset value of the AICT base register (word aligned)
- VEC_W, $clog2(NIRQ), localparam, vector width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- valid  in  1  CPU request valid
- ready  out  1  CPU request done
- addr  in  32  CPU byte address
- dtw  in  32  CPU write data
- dtr  out  32  CPU read data
- rw  in  1  1 = write, 0 = read
- sval, srdy, saddr, sdtw, sdtr, srw  SRAM side, same widths and meaning as the CPU side
- interrupts  in  NIRQ  interrupt lines, synchronous to clk
- iack  in  1  core acknowledges the request (1-cycle pulse)
- handler  out  32  ISR address for vec
- intrq  out  1  interrupt request
- vec  out  VEC_W  selected vector
- nmi  out  1  selected vector is line 0

## Operation
- Register map, byte offsets from BASE (base register): +0 BASE, +4 ENABLE (bit 0 ignored, reads 1), +8 PENDING (write-1-clear), +12 EOI (write any value; reads state in bits [1:0]), +16+4*i HANDLER[i], i < NIRQ. Window = [BASE, BASE+16+4*NIRQ), upper bound exclusive; addr[1:0] ignored.
- In window: SRAM untouched (sval=0); else sval=valid, saddr/sdtw/srw pass-through, ready=srdy, dtr=sdtr combinationally.
- Window access: ready is a registered 1-cycle pulse the cycle after valid is first seen; reads return registered dtr in that same cycle; writes commit on that edge. Master drops valid after ready; valid held longer re-issues.
- Window decode uses BASE as it was at the start of the access; a write to BASE takes effect for the next access.
- Pending: bit i sets on a rising edge of interrupts[i] (previous-cycle sample register). Same-cycle set and W1C clear: set wins.
- Eligible = PENDING & (ENABLE | 1). Priority: lowest index wins.
- FSM IDLE -> REQ when any eligible bit: latch vec, handler=HANDLER[vec], nmi=(vec==0). REQ: intrq=1, vec/handler frozen. REQ + iack -> SERVICE: clear PENDING[vec], intrq=0. SERVICE + EOI write -> IDLE. A NMI edge arriving in SERVICE for a non-NMI vector preempts: SERVICE -> REQ with vec=0; EOI then returns to IDLE (no nesting stack; software re-arms the interrupted line).
- REQ with the latched line cleared by W1C or disabled: drop back to IDLE next cycle, intrq=0.

## Timing
- Reset values: ready=0, dtr=0 (window side), intrq=0, vec=0, handler=0, nmi=0, ENABLE=0, PENDING=0, HANDLER[*]=0, BASE=BASE_RST, state IDLE.
- Edge on interrupts at cycle t -> PENDING set at t+1 -> REQ and intrq=1 at t+2.
- iack at t -> intrq=0 at t+1; iack outside REQ ignored.
- Window access latency 1 cycle; SRAM path 0 added cycles.
- Reset asserted mid-access or mid-service aborts everything immediately.

## Structure
- Shared package aic_pkg: register offsets (OFF_BASE, OFF_ENABLE, OFF_PENDING, OFF_EOI, OFF_HANDLER), state encoding (IDLE=0, REQ=1, SERVICE=2).
- Sub-module aic_prio: parametrised lowest-index priority encoder (NIRQ in -> VEC_W vec + any).

## Test plan
- Reset, read BASE_RST+0 -> dtr=32'h0000_FF00 one cycle after valid, sval=0; read 32'h100 -> sval=1, dtr follows sdtr.
- Write HANDLER[5]=32'h0000_1234, ENABLE=32'h20, pulse interrupts[5] -> intrq=1 two cycles later, vec=5, handler=32'h1234, nmi=0; iack -> intrq=0, PENDING bit 5 clear.
- Lines 3 and 7 enabled, both edges same cycle -> vec=3; iack, EOI -> vec=7 request follows.
- Line 9 disabled, edge on 9 -> PENDING[9]=1, intrq stays 0; enable it -> intrq=1 two cycles later.
- In SERVICE for line 4, edge on line 0 with ENABLE=0 -> intrq=1, vec=0, nmi=1.
- Write BASE=32'h0000_8000 -> next read of 32'h0000_FF00 goes to SRAM, read of 32'h0000_8000 returns 32'h8000.

Source files
------------

// File: rtl/aic_pkg.sv
// Shared definitions for the MMIO interrupt controller: AICT register offsets and FSM states.
package aic_pkg;

  localparam int unsigned OFF_BASE    = 0;
  localparam int unsigned OFF_ENABLE  = 4;
  localparam int unsigned OFF_PENDING = 8;
  localparam int unsigned OFF_EOI     = 12;
  localparam int unsigned OFF_HANDLER = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } aic_state_e;

  // Size in bytes of the AICT window for a given line count.
  function automatic int unsigned win_bytes(input int unsigned nirq);
    return OFF_HANDLER + 4 * nirq;
  endfunction

endpackage

// File: rtl/aic_prio.sv
// Lowest-index-wins priority encoder over the eligible interrupt lines.
module aic_prio
  import aic_pkg::*;
#(
  parameter int unsigned NIRQ  = 24,
  parameter int unsigned VEC_W = $clog2(NIRQ)
) (
  input  logic [NIRQ-1:0]  req,
  output logic [VEC_W-1:0] vec,
  output logic             any
);

  always_comb begin
    vec = '0;
    any = |req;
    for (int i = int'(NIRQ) - 1; i >= 0; i--) begin
      if (req[i]) vec = VEC_W'(i);
    end
  end

endmodule

// File: rtl/mmio_aic.sv
// MMIO front end: decodes the relocatable AICT window, passes other accesses to SRAM,
// and runs an N-line edge-captured interrupt controller with an in-service handshake.
module mmio_aic
  import aic_pkg::*;
#(
  parameter int unsigned NIRQ     = 24,
  parameter logic [31:0] BASE_RST = 32'h0000_FF00
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      valid,
  output logic                      ready,
  input  logic [31:0]               addr,
  input  logic [31:0]               dtw,
  output logic [31:0]               dtr,
  input  logic                      rw,
  output logic                      sval,
  input  logic                      srdy,
  output logic [31:0]               saddr,
  output logic [31:0]               sdtw,
  input  logic [31:0]               sdtr,
  output logic                      srw,
  input  logic [NIRQ-1:0]           interrupts,
  input  logic                      iack,
  output logic [31:0]               handler,
  output logic                      intrq,
  output logic [$clog2(NIRQ)-1:0]   vec,
  output logic                      nmi
);

  localparam int unsigned VEC_W     = $clog2(NIRQ);
  localparam logic [31:0] WIN_BYTES = 32'(win_bytes(NIRQ));

  logic [31:0]      base_q, base_d, dtr_q, dtr_d, handler_q, handler_d;
  logic [NIRQ-1:0]  enable_q, enable_d, pend_q, pend_d, irq_prev_q;
  logic [31:0]      hand_q [NIRQ];
  logic [31:0]      hand_d [NIRQ];
  logic             ready_q, ready_d, intrq_q, intrq_d, nmi_q, nmi_d;
  logic [VEC_W-1:0] vec_q, vec_d, prio_vec_c;
  aic_state_e       state_q, state_d;

  logic [31:0]      off_c, offw_c, rdata_c;
  logic [NIRQ-1:0]  rise_c, eligible_c, clr_c;
  logic             win_hit_c, in_win_c, acc_c, wr_c, eoi_c, prio_any_c;

  // Window decode against the current base; the access in its ready cycle stays on the window side.
  assign off_c     = addr - base_q;
  assign offw_c    = {off_c[31:2], 2'b00};
  assign win_hit_c = (addr >= base_q) && (off_c < WIN_BYTES);
  assign in_win_c  = win_hit_c | ready_q;
  assign acc_c     = valid & win_hit_c & ~ready_q;
  assign wr_c      = acc_c & rw;

  assign sval  = valid & ~in_win_c;
  assign saddr = addr;
  assign sdtw  = dtw;
  assign srw   = rw;
  assign ready = in_win_c ? ready_q : srdy;
  assign dtr   = in_win_c ? dtr_q : sdtr;

  assign rise_c     = interrupts & ~irq_prev_q;
  assign eligible_c = pend_q & (enable_q | NIRQ'(1));

  assign handler = handler_q;
  assign intrq   = intrq_q;
  assign vec     = vec_q;
  assign nmi     = nmi_q;

  aic_prio #(.NIRQ(NIRQ), .VEC_W(VEC_W)) u_prio (
    .req (eligible_c),
    .vec (prio_vec_c),
    .any (prio_any_c)
  );

  // Register read mux.
  always_comb begin
    rdata_c = '0;
    if (offw_c == 32'(OFF_BASE))    rdata_c = base_q;
    if (offw_c == 32'(OFF_ENABLE))  rdata_c = 32'(enable_q | NIRQ'(1));
    if (offw_c == 32'(OFF_PENDING)) rdata_c = 32'(pend_q);
    if (offw_c == 32'(OFF_EOI))     rdata_c = 32'(state_q);
    for (int unsigned i = 0; i < NIRQ; i++) begin
      if (offw_c == 32'(OFF_HANDLER + 4 * i)) rdata_c = hand_q[i];
    end
  end

  // Register writes and the request/service FSM.
  always_comb begin
    base_d    = base_q;
    enable_d  = enable_q;
    hand_d    = hand_q;
    dtr_d     = dtr_q;
    ready_d   = acc_c;
    state_d   = state_q;
    vec_d     = vec_q;
    handler_d = handler_q;
    nmi_d     = nmi_q;
    intrq_d   = intrq_q;
    clr_c     = '0;
    eoi_c     = 1'b0;

    if (acc_c && !rw) dtr_d = rdata_c;
    if (wr_c) begin
      if (offw_c == 32'(OFF_BASE))    base_d   = {dtw[31:2], 2'b00};
      if (offw_c == 32'(OFF_ENABLE))  enable_d = dtw[NIRQ-1:0] & ~NIRQ'(1);
      if (offw_c == 32'(OFF_PENDING)) clr_c    = dtw[NIRQ-1:0];
      if (offw_c == 32'(OFF_EOI))     eoi_c    = 1'b1;
      for (int unsigned i = 0; i < NIRQ; i++) begin
        if (offw_c == 32'(OFF_HANDLER + 4 * i)) hand_d[i] = dtw;
      end
    end

    case (state_q)
      IDLE: begin
        if (prio_any_c) begin
          state_d   = REQ;
          intrq_d   = 1'b1;
          vec_d     = prio_vec_c;
          handler_d = hand_q[prio_vec_c];
          nmi_d     = (prio_vec_c == '0);
        end
      end
      REQ: begin
        if (!eligible_c[vec_q]) begin
          state_d = IDLE;
          intrq_d = 1'b0;
        end else if (iack) begin
          state_d      = SERVICE;
          intrq_d      = 1'b0;
          clr_c[vec_q] = 1'b1;
        end
      end
      SERVICE: begin
        // A pending NMI preempts a normal handler; there is no nesting stack.
        if (eoi_c) begin
          state_d = IDLE;
        end else if (pend_q[0] && vec_q != '0) begin
          state_d   = REQ;
          intrq_d   = 1'b1;
          vec_d     = '0;
          handler_d = hand_q[0];
          nmi_d     = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        intrq_d = 1'b0;
      end
    endcase

    pend_d = (pend_q & ~clr_c) | rise_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q     <= BASE_RST;
      enable_q   <= '0;
      pend_q     <= '0;
      irq_prev_q <= '0;
      hand_q     <= '{default: '0};
      dtr_q      <= '0;
      ready_q    <= 1'b0;
      state_q    <= IDLE;
      vec_q      <= '0;
      handler_q  <= '0;
      nmi_q      <= 1'b0;
      intrq_q    <= 1'b0;
    end else begin
      base_q     <= base_d;
      enable_q   <= enable_d;
      pend_q     <= pend_d;
      irq_prev_q <= interrupts;
      hand_q     <= hand_d;
      dtr_q      <= dtr_d;
      ready_q    <= ready_d;
      state_q    <= state_d;
      vec_q      <= vec_d;
      handler_q  <= handler_d;
      nmi_q      <= nmi_d;
      intrq_q    <= intrq_d;
    end
  end

endmodule

// File: tb/tb_mmio_aic.sv
// Directed and randomized bench for mmio_aic against a bitmask-level model of the controller.
module tb_mmio_aic;

  localparam int unsigned NIRQ     = 24;
  localparam int unsigned VEC_W    = $clog2(NIRQ);
  localparam logic [31:0] SRAM_XOR = 32'hA5A5_5A5A;

  logic              clk = 1'b0;
  logic              reset;
  logic              valid, ready, rw, sval, srdy, srw, iack, intrq, nmi;
  logic [31:0]       addr, dtw, dtr, saddr, sdtw, sdtr, handler;
  logic [NIRQ-1:0]   interrupts;
  logic [VEC_W-1:0]  vec;

  int                ncmp = 0;
  int                nerr = 0;
  logic [31:0]       hm [NIRQ];
  logic [31:0]       base_m;
  logic [31:0]       rdv;
  logic [NIRQ-1:0]   en, lines, elig;
  int                v;

  always #5 clk = ~clk;

  // SRAM responder: always ready, data is a fixed function of the address.
  assign srdy = sval;
  assign sdtr = saddr ^ SRAM_XOR;

  mmio_aic #(.NIRQ(NIRQ), .BASE_RST(32'h0000_FF00)) dut (
    .clk(clk), .reset(reset), .valid(valid), .ready(ready), .addr(addr), .dtw(dtw),
    .dtr(dtr), .rw(rw), .sval(sval), .srdy(srdy), .saddr(saddr), .sdtw(sdtw),
    .sdtr(sdtr), .srw(srw), .interrupts(interrupts), .iack(iack), .handler(handler),
    .intrq(intrq), .vec(vec), .nmi(nmi)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One CPU access; window accesses take one cycle, SRAM accesses complete combinationally.
  task automatic bus(input string tag, input logic [31:0] a, input logic w,
                     input logic [31:0] d, input logic win, output logic [31:0] rd);
    @(negedge clk);
    valid = 1'b1; rw = w; addr = a; dtw = d;
    #1;
    if (win) begin
      chk({tag, "_sval"}, 32'(sval), 32'd0);
      chk({tag, "_rdy0"}, 32'(ready), 32'd0);
      @(negedge clk);
      chk({tag, "_rdy1"}, 32'(ready), 32'd1);
      rd = dtr;
    end else begin
      chk({tag, "_sval"}, 32'(sval), 32'd1);
      chk({tag, "_rdy"}, 32'(ready), 32'd1);
      rd = dtr;
      @(negedge clk);
    end
    valid = 1'b0; rw = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] unused_rd;
    bus("wr", a, 1'b1, d, 1'b1, unused_rd);
  endtask

  task automatic rdchk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus(tag, a, 1'b0, 32'd0, 1'b1, d);
    chk(tag, d, exp);
  endtask

  task automatic pulse(input logic [NIRQ-1:0] m);
    @(negedge clk); interrupts = m;
    @(negedge clk); interrupts = '0;
  endtask

  task automatic wait_intrq(input string tag);
    int n;
    n = 0;
    while (intrq !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_intrq"}, 32'(intrq), 32'd1);
  endtask

  task automatic expect_req(input string tag, input int ve);
    chk({tag, "_vec"}, 32'(vec), 32'(ve));
    chk({tag, "_handler"}, handler, hm[ve]);
    chk({tag, "_nmi"}, 32'(nmi), (ve == 0) ? 32'd1 : 32'd0);
  endtask

  task automatic do_ack(input string tag);
    @(negedge clk); iack = 1'b1;
    @(negedge clk); iack = 1'b0;
    chk({tag, "_ack_intrq"}, 32'(intrq), 32'd0);
  endtask

  function automatic int lowest(input logic [NIRQ-1:0] m);
    for (int i = 0; i < int'(NIRQ); i++) if (m[i]) return i;
    return -1;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    valid = 1'b0; rw = 1'b0; addr = 32'h0000_FF00; dtw = '0;
    interrupts = '0; iack = 1'b0; reset = 1'b1;
    base_m = 32'h0000_FF00;
    for (int i = 0; i < int'(NIRQ); i++) hm[i] = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_intrq", 32'(intrq), 32'd0);
    chk("rst_vec", 32'(vec), 32'd0);
    chk("rst_handler", handler, 32'd0);
    chk("rst_nmi", 32'(nmi), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_dtr", dtr, 32'd0);

    // Register read vs SRAM pass-through.
    rdchk("rd_base", base_m, 32'h0000_FF00);
    bus("rd_sram", 32'h0000_0100, 1'b0, 32'd0, 1'b0, rdv);
    chk("rd_sram_data", rdv, 32'h0000_0100 ^ SRAM_XOR);

    // Single enabled line, exact two-cycle request latency.
    hm[5] = 32'h0000_1234;
    wr(base_m + 16 + 4 * 5, hm[5]);
    wr(base_m + 4, 32'h20);
    pulse(NIRQ'(1) << 5);
    chk("l5_early", 32'(intrq), 32'd0);
    @(negedge clk);
    chk("l5_req", 32'(intrq), 32'd1);
    expect_req("l5", 5);
    do_ack("l5");
    rdchk("l5_pend", base_m + 8, 32'd0);
    rdchk("l5_state_svc", base_m + 12, 32'd2);
    wr(base_m + 12, 32'hDEAD_BEEF);
    rdchk("l5_state_idle", base_m + 12, 32'd0);

    // Two simultaneous edges: lowest index first, the other after EOI.
    wr(base_m + 4, (32'd1 << 3) | (32'd1 << 7));
    pulse((NIRQ'(1) << 3) | (NIRQ'(1) << 7));
    @(negedge clk);
    chk("l37_req", 32'(intrq), 32'd1);
    expect_req("l3", 3);
    do_ack("l3");
    wr(base_m + 12, 32'd0);
    wait_intrq("l7");
    expect_req("l7", 7);
    do_ack("l7");
    wr(base_m + 12, 32'd0);

    // Disabled line stays pending, enabling it raises the request two cycles later.
    wr(base_m + 4, 32'd0);
    pulse(NIRQ'(1) << 9);
    repeat (3) @(negedge clk);
    chk("l9_masked", 32'(intrq), 32'd0);
    rdchk("l9_pend", base_m + 8, 32'd1 << 9);
    wr(base_m + 4, 32'd1 << 9);
    chk("l9_en_early", 32'(intrq), 32'd0);
    @(negedge clk);
    chk("l9_en_req", 32'(intrq), 32'd1);
    expect_req("l9", 9);
    do_ack("l9");
    wr(base_m + 12, 32'd0);

    // NMI edge during service of line 4 preempts even with ENABLE cleared.
    hm[0] = 32'h0000_0A00;
    wr(base_m + 16, hm[0]);
    wr(base_m + 4, 32'd1 << 4);
    pulse(NIRQ'(1) << 4);
    wait_intrq("l4");
    expect_req("l4", 4);
    do_ack("l4");
    wr(base_m + 4, 32'd0);
    pulse(NIRQ'(1));
    chk("nmi_early", 32'(intrq), 32'd0);
    @(negedge clk);
    chk("nmi_req", 32'(intrq), 32'd1);
    expect_req("nmi", 0);
    do_ack("nmi");
    rdchk("nmi_state_svc", base_m + 12, 32'd2);
    wr(base_m + 12, 32'd0);
    rdchk("nmi_state_idle", base_m + 12, 32'd0);
    rdchk("nmi_pend", base_m + 8, 32'd0);

    // W1C of the requested line while in REQ withdraws the request.
    wr(base_m + 4, 32'd1 << 2);
    pulse(NIRQ'(1) << 2);
    @(negedge clk);
    chk("w1c_req", 32'(intrq), 32'd1);
    wr(base_m + 8, 32'd1 << 2);
    @(negedge clk);
    chk("w1c_drop", 32'(intrq), 32'd0);
    rdchk("w1c_state", base_m + 12, 32'd0);

    // Relocate the window and probe its edges.
    wr(base_m, 32'h0000_8000);
    base_m = 32'h0000_8000;
    bus("old_base", 32'h0000_FF00, 1'b0, 32'd0, 1'b0, rdv);
    chk("old_base_data", rdv, 32'h0000_FF00 ^ SRAM_XOR);
    rdchk("new_base", 32'h0000_8000, 32'h0000_8000);
    rdchk("unaligned_en", 32'h0000_8006, 32'd1 << 2 | 32'd1);
    rdchk("last_handler", base_m + 16 + 4 * (NIRQ - 1), hm[NIRQ-1]);
    bus("past_win", base_m + 16 + 4 * NIRQ, 1'b0, 32'd0, 1'b0, rdv);
    chk("past_win_data", rdv, (base_m + 16 + 4 * NIRQ) ^ SRAM_XOR);

    // Randomized: random handlers, enables and simultaneous edge sets.
    for (int i = 0; i < int'(NIRQ); i++) begin
      hm[i] = $urandom;
      wr(base_m + 16 + 4 * i, hm[i]);
    end
    for (int t = 0; t < 16; t++) begin
      en    = NIRQ'($urandom);
      lines = NIRQ'($urandom) | (NIRQ'(1) << $urandom_range(NIRQ - 1, 0));
      wr(base_m + 4, 32'(en));
      rdchk("rnd_enable", base_m + 4, 32'(en | NIRQ'(1)));
      pulse(lines);
      elig = lines & (en | NIRQ'(1));
      while (elig != '0) begin
        v = lowest(elig);
        wait_intrq("rnd");
        expect_req("rnd", v);
        do_ack("rnd");
        wr(base_m + 12, 32'd0);
        elig[v] = 1'b0;
      end
      repeat (3) @(negedge clk);
      chk("rnd_quiet", 32'(intrq), 32'd0);
      rdchk("rnd_pend", base_m + 8, 32'(lines & ~(en | NIRQ'(1))));
      wr(base_m + 8, 32'hFFFF_FFFF);
      rdchk("rnd_pend_clr", base_m + 8, 32'd0);
    end

    // Reset during an active request clears everything at once.
    wr(base_m + 4, 32'd1 << 6);
    pulse(NIRQ'(1) << 6);
    wait_intrq("prerst");
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_intrq", 32'(intrq), 32'd0);
    chk("midrst_vec", 32'(vec), 32'd0);
    chk("midrst_handler", handler, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    base_m = 32'h0000_FF00;
    rdchk("post_rst_base", base_m, 32'h0000_FF00);
    rdchk("post_rst_enable", base_m + 4, 32'd1);
    rdchk("post_rst_handler", base_m + 16 + 4 * 5, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
